pes_sdw_evcnt: RTL and testbench

//  Downstream consumer of the sequence-detector output: counts single-cycle detect

---
 rtl/pes_sdw_pkg.sv | 22 ++
 rtl/pes_sat_cnt.sv | 52 +++++
 rtl/pes_sdw_evcnt.sv | 135 +++++++++++++
 tb/tb_pes_sdw_evcnt.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pes_sdw_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pes_sdw_pkg
// Purpose : Shared types and default sizes for the windowed detect-pulse
//           event counter (pes_sdw_evcnt) and its saturating accumulator.
// Contents: slot_state_t  - result slot state (EMPTY / FULL)
//           c_DEF_*       - default window length, count width, id width
// Revision: 1.0 - initial release
// ============================================================================
package pes_sdw_pkg;

    localparam int c_DEF_WIN_LEN = 16;
    localparam int c_DEF_CNT_W   = 5;
    localparam int c_DEF_ID_W    = 4;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/pes_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module  : pes_sat_cnt
// Purpose : Saturating up-counter with a sticky saturation flag. The
//           o_nxt_* outputs present the value including this cycle's
//           increment, so a caller can capture the final count of a window
//           on the same edge that clears the counter.
// Ports   : clk, rst       - clock, asynchronous active-high reset
//           i_inc          - add one this cycle (clipped at all-ones)
//           i_clr          - clear count and flag on this edge
//           o_nxt_cnt      - count after this cycle's increment
//           o_nxt_sat      - sticky flag after this cycle's increment
// Revision: 1.0 - initial release
// ============================================================================
module pes_sat_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_nxt_cnt,
    output logic         o_nxt_sat
);

    localparam logic [W-1:0] c_MAX = '1;

    logic [W-1:0] r_cnt;
    logic         r_sat;
    logic         w_clip;

    // An increment arriving while already at the ceiling is the only event
    // that sets the sticky flag.
    assign w_clip    = i_inc && (r_cnt == c_MAX);
    assign o_nxt_cnt = (i_inc && !w_clip) ? r_cnt + 1'b1 : r_cnt;
    assign o_nxt_sat = r_sat | w_clip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_cnt <= o_nxt_cnt;
            r_sat <= o_nxt_sat;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pes_sdw_evcnt.sv
`default_nettype none
// ============================================================================
// Module  : pes_sdw_evcnt
// Purpose : Counts single-cycle detect pulses over windows of WIN_LEN enabled
//           clocks and offers each window's count downstream on a
//           valid/ready slot. Windows closing while the slot is held are
//           discarded and flagged with a one-cycle drop pulse.
// Ports   : clk, reset     - clock, asynchronous active-high reset
//           en             - advance window / sample det
//           det            - detect pulse
//           cnt_out/id/sat - closed-window count, index, saturation flag
//           cnt_valid      - result slot full
//           cnt_ready      - downstream accepts
//           drop           - a closed window's result was discarded
// Revision: 1.0 - initial release
// ============================================================================
module pes_sdw_evcnt
    import pes_sdw_pkg::*;
#(
    parameter int WIN_LEN = c_DEF_WIN_LEN,
    parameter int CNT_W   = c_DEF_CNT_W,
    parameter int ID_W    = c_DEF_ID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             det,
    output logic [CNT_W-1:0] cnt_out,
    output logic [ID_W-1:0]  cnt_id,
    output logic             cnt_sat,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             drop
);

    localparam int                c_WPOS_W    = $clog2(WIN_LEN);
    localparam logic [c_WPOS_W-1:0] c_WPOS_LAST = c_WPOS_W'(WIN_LEN - 1);

    logic [c_WPOS_W-1:0] r_wpos;
    logic [ID_W-1:0]     r_next_id;
    slot_state_t         r_state;
    slot_state_t         w_state_nxt;
    logic [CNT_W-1:0]    r_cnt_out;
    logic [ID_W-1:0]     r_cnt_id;
    logic                r_cnt_sat;
    logic                r_drop;

    logic                w_close;
    logic                w_load;
    logic                w_drop;
    logic [CNT_W-1:0]    w_acc_nxt;
    logic                w_sat_nxt;

    assign w_close = en && (r_wpos == c_WPOS_LAST);

    // Accumulator clears on the close edge; its next-value outputs already
    // include the closing cycle's det, which is what gets captured.
    pes_sat_cnt #(
        .W (CNT_W)
    ) u_acc (
        .clk       (clk),
        .rst       (reset),
        .i_inc     (en & det),
        .i_clr     (w_close),
        .o_nxt_cnt (w_acc_nxt),
        .o_nxt_sat (w_sat_nxt)
    );

    // Window position and index of the window currently being counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wpos    <= '0;
            r_next_id <= '0;
        end else if (w_close) begin
            r_wpos    <= '0;
            r_next_id <= r_next_id + 1'b1;
        end else if (en) begin
            r_wpos    <= r_wpos + 1'b1;
        end
    end

    // Slot FSM: a close loads the slot if it is empty or is being emptied
    // by a transfer on the same edge; otherwise the new result is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            SLOT_EMPTY: begin
                if (w_close) begin
                    w_load      = 1'b1;
                    w_state_nxt = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (w_close) begin
                    if (cnt_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (cnt_ready) begin
                    w_state_nxt = SLOT_EMPTY;
                end
            end
            default: w_state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= SLOT_EMPTY;
            r_cnt_out <= '0;
            r_cnt_id  <= '0;
            r_cnt_sat <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop;
            if (w_load) begin
                r_cnt_out <= w_acc_nxt;
                r_cnt_id  <= r_next_id;
                r_cnt_sat <= w_sat_nxt;
            end
        end
    end

    assign cnt_out   = r_cnt_out;
    assign cnt_id    = r_cnt_id;
    assign cnt_sat   = r_cnt_sat;
    assign cnt_valid = (r_state == SLOT_FULL);
    assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pes_sdw_evcnt.sv
`default_nettype none
// ============================================================================
// Module  : tb_pes_sdw_evcnt
// Purpose : Self-checking bench for pes_sdw_evcnt. Two instances share one
//           stimulus: A with default widths, B with CNT_W=3 to reach
//           saturation. A window-level model predicts the slot contents,
//           directed scenarios pin literal values, then random traffic runs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pes_sdw_evcnt;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       det = 1'b0;
    logic       cnt_ready = 1'b0;

    logic [4:0] a_out;
    logic [3:0] a_id;
    logic       a_sat, a_valid, a_drop;
    logic [2:0] b_out;
    logic [3:0] b_id;
    logic       b_sat, b_valid, b_drop;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    // model state
    int m_pos = 0, m_cnt = 0, m_id = 0, m_res = 0, m_oid = 0;
    bit m_full = 1'b0, m_drop = 1'b0;

    always #5 clk = ~clk;

    pes_sdw_evcnt u_dut_a (
        .clk(clk), .reset(reset), .en(en), .det(det),
        .cnt_out(a_out), .cnt_id(a_id), .cnt_sat(a_sat),
        .cnt_valid(a_valid), .cnt_ready(cnt_ready), .drop(a_drop)
    );

    pes_sdw_evcnt #(.CNT_W(3)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .det(det),
        .cnt_out(b_out), .cnt_id(b_id), .cnt_sat(b_sat),
        .cnt_valid(b_valid), .cnt_ready(cnt_ready), .drop(b_drop)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clip(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Window-level reference: raw pulse count per window, clipped only
    // when reported; slot is a single-entry buffer.
    initial begin
        int  total;
        bit  close, xfer;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_pos = 0; m_cnt = 0; m_id = 0; m_res = 0; m_oid = 0;
                m_full = 0; m_drop = 0;
            end else begin
                xfer   = m_full && cnt_ready;
                close  = en && (m_pos == WIN - 1);
                total  = m_cnt + ((en && det) ? 1 : 0);
                m_drop = 0;
                if (close) begin
                    if (!m_full || xfer) begin
                        m_full = 1; m_res = total; m_oid = m_id;
                    end else begin
                        m_drop = 1;
                    end
                    m_id  = (m_id + 1) % 16;
                    m_pos = 0;
                    m_cnt = 0;
                end else begin
                    if (xfer) m_full = 0;
                    if (en) begin
                        m_pos++;
                        m_cnt = total;
                    end
                end
            end
        end
    end

    // Compare process, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            chk("a_valid", a_valid, m_full);
            chk("b_valid", b_valid, m_full);
            chk("a_drop", a_drop, m_drop);
            chk("b_drop", b_drop, m_drop);
            if (m_full) begin
                chk("a_out", a_out, clip(m_res, 5));
                chk("a_sat", a_sat, (m_res > 31) ? 1 : 0);
                chk("a_id", a_id, m_oid);
                chk("b_out", b_out, clip(m_res, 3));
                chk("b_sat", b_sat, (m_res > 7) ? 1 : 0);
                chk("b_id", b_id, m_oid);
            end
        end
    end

    task automatic cyc(input bit e, input bit d, input bit r);
        en = e; det = d; cnt_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        cyc(0, 0, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_out", a_out, 0);
        chk("rst_id", a_id, 0);
        chk("rst_drop", a_drop, 0);
        reset = 1'b0;

        // 1: alternating det over one window
        for (int i = 0; i < WIN; i++) cyc(1, (i % 2) == 0, 1);
        chk("t1_valid", a_valid, 1);
        chk("t1_out", a_out, 8);
        chk("t1_id", a_id, 0);
        chk("t1_sat", a_sat, 0);
        cyc(0, 0, 1);
        chk("t1_valid_off", a_valid, 0);

        // 2: saturation on the narrow instance
        for (int i = 0; i < WIN; i++) cyc(1, 1, 1);
        chk("t2_b_out", b_out, 7);
        chk("t2_b_sat", b_sat, 1);
        chk("t2_a_out", a_out, 16);
        chk("t2_a_sat", a_sat, 0);
        for (int i = 0; i < WIN; i++) cyc(1, 0, 1);
        chk("t2_b_out0", b_out, 0);
        chk("t2_b_sat0", b_sat, 0);
        chk("t2_id", b_id, 2);

        // 3: back-pressure over two windows
        do_reset();
        for (int i = 0; i < WIN; i++) cyc(1, (i % 2) == 0, 0);
        chk("t3_valid", a_valid, 1);
        chk("t3_out", a_out, 8);
        for (int i = 0; i < WIN; i++) cyc(1, (i % 2) == 1, 0);
        chk("t3_drop", a_drop, 1);
        chk("t3_hold_out", a_out, 8);
        chk("t3_hold_id", a_id, 0);
        cyc(0, 0, 1);
        chk("t3_drop_off", a_drop, 0);
        chk("t3_taken", a_valid, 0);
        for (int i = 0; i < WIN; i++) cyc(1, (i % 2) == 0, 1);
        chk("t3_next_id", a_id, 2);
        chk("t3_next_out", a_out, 8);

        // 4: close and transfer on the same edge
        do_reset();
        for (int i = 0; i < WIN; i++) cyc(1, 0, 0);
        for (int i = 0; i < WIN - 1; i++) cyc(1, 1, 0);
        cyc(1, 1, 1);
        chk("t4_valid", a_valid, 1);
        chk("t4_id", a_id, 1);
        chk("t4_out", a_out, 16);
        chk("t4_drop", a_drop, 0);

        // 5: enable gap mid-window
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1);
        chk("t5_no_close", a_valid, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1);
        chk("t5_close", a_valid, 1);
        chk("t5_out", a_out, 16);

        // 6: asynchronous reset with slot full, mid-window
        do_reset();
        for (int i = 0; i < WIN; i++) cyc(1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", a_valid, 0);
        chk("t6_out", a_out, 0);
        chk("t6_id", a_id, 0);
        chk("t6_b_sat", b_sat, 0);
        chk("t6_drop", a_drop, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < WIN; i++) cyc(1, 1, 1);
        chk("t6_first_id", a_id, 0);
        chk("t6_first_out", a_out, 16);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(99) < 80, $urandom_range(1) == 1,
                    $urandom_range(99) < 60);
            end
        end

        done = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
